// File: rtl/bishift_pkg.sv
// bishift_pkg: shared types and constants for the bishift_loader slice.
//   state_t   : loader FSM states (IDLE, SHIFT, DONE)
//   DIR_LEFT  : load_dir value selecting a left shift (bits enter through sin_l)
//   DIR_RIGHT : load_dir value selecting a right shift (bits enter through sin_r)
package bishift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bishift_bit_cnt.sv
// bishift_bit_cnt: bit counter for the serial load sequence.
//   i_clk    : system clock, rising edge
//   i_reset  : asynchronous active-high reset
//   i_clear  : synchronous clear to 0 (wins over i_enable)
//   i_enable : increment by one
//   o_count  : current count, CNT_W bits
//   o_last   : count == WIDTH-1
module bishift_bit_cnt
    import bishift_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bishift_loader.sv
// bishift_loader: accepts a parallel word over valid/ready and drives the mode,
// sin_r and sin_l inputs of a bidirectional shift register for WIDTH clocks so
// that the word ends up in the register.
//   i_clk, i_reset     : clock and asynchronous active-high reset
//   i_load_valid/o_load_ready, i_load_data, i_load_dir : upstream handshake
//   o_mode, o_sin_r, o_sin_l : shift register controls (registered)
//   o_busy             : high while the word is being shifted
//   o_done             : one-cycle pulse after the last bit
//   i_q_in, o_verify_err : loaded-word check, only with BISHIFT_VERIFY_EN
// Optional feature macro: BISHIFT_VERIFY_EN (read-back comparison in DONE).
module bishift_loader
    import bishift_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_load_dir,
    output logic             o_mode,
    output logic             o_sin_r,
    output logic             o_sin_l,
    output logic             o_busy,
    output logic             o_done,
    input  logic [WIDTH-1:0] i_q_in,
    output logic             o_verify_err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic             r_mode;
    logic             r_sin_r;
    logic             r_sin_l;
    logic             r_busy;
    logic             r_done;

    logic             w_handshake;
    logic             w_last;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_next_idx;
    logic [CNT_W-1:0] w_next_pos;
    logic             w_next_bit;
    logic             w_first_bit;

    assign o_load_ready = (r_state == IDLE) && !i_reset;
    assign w_handshake  = i_load_valid && o_load_ready;

    // Counter is cleared on the last edge too, so it rests at 0 for any WIDTH.
    bishift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_handshake || ((r_state == SHIFT) && w_last)),
        .i_enable (r_state == SHIFT),
        .o_count  (w_count),
        .o_last   (w_last)
    );

    // Right shift sends D[0] first; left shift sends D[WIDTH-1] first.
    assign w_first_bit = (i_load_dir == DIR_RIGHT) ? i_load_data[0] : i_load_data[WIDTH-1];
    assign w_next_idx  = w_count + 1'b1;
    assign w_next_pos  = (r_mode == DIR_RIGHT) ? w_next_idx : (CNT_W'(WIDTH - 1) - w_next_idx);
    assign w_next_bit  = r_shadow[w_next_pos];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_mode   <= 1'b0;
            r_sin_r  <= 1'b0;
            r_sin_l  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_shadow <= i_load_data;
                        r_mode   <= i_load_dir;
                        r_busy   <= 1'b1;
                        r_sin_r  <= (i_load_dir == DIR_RIGHT) ? w_first_bit : 1'b0;
                        r_sin_l  <= (i_load_dir == DIR_LEFT)  ? w_first_bit : 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_sin_r <= 1'b0;
                        r_sin_l <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_sin_r <= (r_mode == DIR_RIGHT) ? w_next_bit : 1'b0;
                        r_sin_l <= (r_mode == DIR_LEFT)  ? w_next_bit : 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mode  = r_mode;
    assign o_sin_r = r_sin_r;
    assign o_sin_l = r_sin_l;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

`ifdef BISHIFT_VERIFY_EN
    logic r_verify_err;

    // Sticky until the next accepted word; sampled while the register holds the word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_verify_err <= 1'b0;
        end else if (w_handshake) begin
            r_verify_err <= 1'b0;
        end else if (r_state == DONE) begin
            r_verify_err <= (i_q_in != r_shadow);
        end
    end

    assign o_verify_err = r_verify_err;
`else
    logic w_unused_q_in;

    assign w_unused_q_in = ^i_q_in;
    assign o_verify_err  = 1'b0;
`endif

endmodule
